// File: rtl/legv8_enc_pkg.sv
// Shared types and constants for the LEGv8 instruction encoder: descriptor classes,
// per-class opcodes, immediate widths and range-check helpers.
package legv8_enc_pkg;

  typedef enum logic [3:0] {
    CLS_ADD  = 4'd0,
    CLS_SUB  = 4'd1,
    CLS_AND  = 4'd2,
    CLS_ORR  = 4'd3,
    CLS_ADDI = 4'd4,
    CLS_SUBI = 4'd5,
    CLS_LDUR = 4'd6,
    CLS_STUR = 4'd7,
    CLS_CBZ  = 4'd8,
    CLS_B    = 4'd9,
    CLS_MOVZ = 4'd10
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;

  localparam int unsigned IMM_W      = 26;
  localparam int unsigned IMM_I_W    = 12;
  localparam int unsigned IMM_D_W    = 9;
  localparam int unsigned IMM_CB_W   = 19;
  localparam int unsigned IMM_MOVZ_W = 16;

  // True when every bit above the sign bit of a w-bit field repeats that sign bit.
  function automatic logic fits_signed(input logic [IMM_W-1:0] imm, input int unsigned w);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < IMM_W; i++) begin
      if (i >= w && imm[i] != imm[w-1]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic fits_unsigned(input logic [IMM_W-1:0] imm, input int unsigned w);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < IMM_W; i++) begin
      if (i >= w && imm[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/legv8_field_pack.sv
// Combinational packer: descriptor class and fields to a 32-bit LEGv8 word plus a
// legality flag (illegal class or immediate out of range for the format).
module legv8_field_pack
  import legv8_enc_pkg::*;
(
  input  logic [3:0]       cls_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rn_i,
  input  logic [4:0]       rm_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic [1:0]       hw_i,
  output logic [31:0]      word_o,
  output logic             legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    case (cls_i)
      CLS_ADD: begin
        word_o  = {OP_ADD, rm_i, 6'd0, rn_i, rd_i};
        legal_o = 1'b1;
      end
      CLS_SUB: begin
        word_o  = {OP_SUB, rm_i, 6'd0, rn_i, rd_i};
        legal_o = 1'b1;
      end
      CLS_AND: begin
        word_o  = {OP_AND, rm_i, 6'd0, rn_i, rd_i};
        legal_o = 1'b1;
      end
      CLS_ORR: begin
        word_o  = {OP_ORR, rm_i, 6'd0, rn_i, rd_i};
        legal_o = 1'b1;
      end
      CLS_ADDI: begin
        word_o  = {OP_ADDI, imm_i[11:0], rn_i, rd_i};
        legal_o = fits_unsigned(imm_i, IMM_I_W);
      end
      CLS_SUBI: begin
        word_o  = {OP_SUBI, imm_i[11:0], rn_i, rd_i};
        legal_o = fits_unsigned(imm_i, IMM_I_W);
      end
      // STUR carries its source register Rt in the rd field, same slot as LDUR's target.
      CLS_LDUR: begin
        word_o  = {OP_LDUR, imm_i[8:0], 2'b00, rn_i, rd_i};
        legal_o = fits_signed(imm_i, IMM_D_W);
      end
      CLS_STUR: begin
        word_o  = {OP_STUR, imm_i[8:0], 2'b00, rn_i, rd_i};
        legal_o = fits_signed(imm_i, IMM_D_W);
      end
      CLS_CBZ: begin
        word_o  = {OP_CBZ, imm_i[18:0], rd_i};
        legal_o = fits_signed(imm_i, IMM_CB_W);
      end
      CLS_B: begin
        word_o  = {OP_B, imm_i};
        legal_o = 1'b1;
      end
      CLS_MOVZ: begin
        word_o  = {OP_MOVZ, hw_i, imm_i[15:0], rd_i};
        legal_o = fits_unsigned(imm_i, IMM_MOVZ_W);
      end
      default: begin
        word_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/legv8_insn_encoder.sv
// Streaming LEGv8 encoder / imem loader: accepts descriptors over valid/ready, packs them
// and writes consecutive words through a single output register.
//  state | meaning
//  IDLE  | after reset, waiting for start
//  LOAD  | accepting descriptors, issuing imem writes
//  DONE  | last descriptor retired; waiting for a new start
module legv8_insn_encoder
  import legv8_enc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [25:0]       in_imm,
  input  logic [1:0]        in_hw,
  input  logic              in_last,
  output logic              imem_wvalid,
  input  logic              imem_wready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [CNT_W-1:0]  words,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic              last_seen_q, last_seen_d;
  logic              wvalid_q, wvalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              err_q, err_d;

  logic [31:0] pack_word;
  logic        pack_legal;
  logic        accept;
  logic        wr_fire;

  legv8_field_pack u_pack (
    .cls_i   (in_class),
    .rd_i    (in_rd),
    .rn_i    (in_rn),
    .rm_i    (in_rm),
    .imm_i   (in_imm),
    .hw_i    (in_hw),
    .word_o  (pack_word),
    .legal_o (pack_legal)
  );

  assign in_ready = (state_q == ST_LOAD) && !last_seen_q && (!wvalid_q || imem_wready);
  assign accept   = in_valid && in_ready;
  assign wr_fire  = wvalid_q && imem_wready;

  always_comb begin
    state_d     = state_q;
    last_seen_d = last_seen_q;
    wvalid_d    = wvalid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    words_d     = words_q;
    err_d       = err_q;

    if (wr_fire) begin
      addr_d   = addr_q + ADDR_W'(4);
      words_d  = words_q + CNT_W'(1);
      wvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD;
          last_seen_d = 1'b0;
          addr_d      = BASE_ADDR;
          words_d     = '0;
          err_d       = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (pack_legal) begin
            wvalid_d = 1'b1;
            wdata_d  = pack_word;
          end else begin
            err_d = 1'b1;
          end
          if (in_last) last_seen_d = 1'b1;
        end
        // Leave only once the final word (if any) has drained from the output register.
        if (last_seen_q && (!wvalid_q || wr_fire)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q     <= ST_IDLE;
      last_seen_q <= 1'b0;
      wvalid_q    <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      words_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_seen_q <= last_seen_d;
      wvalid_q    <= wvalid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      words_q     <= words_d;
      err_q       <= err_d;
    end
  end

  assign imem_wvalid = wvalid_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign words       = words_q;
  assign err         = err_q;
  assign done        = (state_q == ST_DONE);

endmodule
